ex_muldiv_unit: RTL and testbench

Iterative RV64M multiply/divide unit in the EX stage.
- Accepts one M-extension op from ID_EX and computes it over multiple cycles.
- Drives busy_o, which the pipeline controller takes as alu_mul_div_valid_ex_i (stall PC/Pre_IF/IF_ID, flush EX_MEM) until the result is ready.
- Result goes to the EX result mux for one cycle.

---
 rtl/muldiv_pkg.sv | 63 ++++++
 rtl/muldiv_iter_core.sv | 92 +++++++++
 rtl/ex_muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the M-extension multiply/divide path.
// Used by the ID decoder (op encodings) and by ex_muldiv_unit (state, decode).
package muldiv_pkg;

   localparam int unsigned ITER_D = 64;
   localparam int unsigned ITER_W = 32;

   typedef enum logic [3:0] {
      OP_MUL    = 4'd0,
      OP_MULH   = 4'd1,
      OP_MULHSU = 4'd2,
      OP_MULHU  = 4'd3,
      OP_DIV    = 4'd4,
      OP_DIVU   = 4'd5,
      OP_REM    = 4'd6,
      OP_REMU   = 4'd7,
      OP_MULW   = 4'd8,
      OP_DIVW   = 4'd9,
      OP_DIVUW  = 4'd10,
      OP_REMW   = 4'd11,
      OP_REMUW  = 4'd12
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } muldiv_state_e;

   // Per-op control bits: divide vs multiply, remainder select, 32-bit form,
   // high product half, and signedness of each operand.
   typedef struct packed {
      logic div;
      logic rem;
      logic word;
      logic hi;
      logic s1;
      logic s2;
   } op_dec_t;

   function automatic op_dec_t decode_op(input logic [3:0] op);
      op_dec_t d;
      d = '0;
      case (op)
         OP_MUL:    begin d.s1 = 1'b1; d.s2 = 1'b1; end
         OP_MULH:   begin d.hi = 1'b1; d.s1 = 1'b1; d.s2 = 1'b1; end
         OP_MULHSU: begin d.hi = 1'b1; d.s1 = 1'b1; end
         OP_MULHU:  begin d.hi = 1'b1; end
         OP_DIV:    begin d.div = 1'b1; d.s1 = 1'b1; d.s2 = 1'b1; end
         OP_DIVU:   begin d.div = 1'b1; end
         OP_REM:    begin d.div = 1'b1; d.rem = 1'b1; d.s1 = 1'b1; d.s2 = 1'b1; end
         OP_REMU:   begin d.div = 1'b1; d.rem = 1'b1; end
         OP_MULW:   begin d.word = 1'b1; d.s1 = 1'b1; d.s2 = 1'b1; end
         OP_DIVW:   begin d.div = 1'b1; d.word = 1'b1; d.s1 = 1'b1; d.s2 = 1'b1; end
         OP_DIVUW:  begin d.div = 1'b1; d.word = 1'b1; end
         OP_REMW:   begin d.div = 1'b1; d.rem = 1'b1; d.word = 1'b1; d.s1 = 1'b1; d.s2 = 1'b1; end
         OP_REMUW:  begin d.div = 1'b1; d.rem = 1'b1; d.word = 1'b1; end
         default:   d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: unsigned radix-2 iterative datapath.
//   Multiply: shift-add, multiplicand shifts left, multiplier shifts right.
//   Divide:   restoring, quotient bits shifted into opb from the right.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         abort: clears counter and datapath
//   load        latch operands a/b and iteration count n_iter
//   is_div      1 = divide, 0 = multiply (sampled on load)
//   step        perform one iteration (ignored when counter is 0)
//   last        counter == 1, i.e. this step is the final one
//   prod        2*XLEN product; quo/rem unsigned quotient/remainder
module muldiv_iter_core #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                load,
   input  logic                is_div,
   input  logic [CNT_W-1:0]    n_iter,
   input  logic [XLEN-1:0]     a,
   input  logic [XLEN-1:0]     b,
   input  logic                step,
   output logic                last,
   output logic [2*XLEN-1:0]   prod,
   output logic [XLEN-1:0]     quo,
   output logic [XLEN-1:0]     rem
);

   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] opa;
   logic [XLEN-1:0]   opb;
   logic [CNT_W-1:0]  count;
   logic              div_mode;
   logic [XLEN:0]     rem_sh;
   logic [XLEN+1:0]   trial;
   logic [CNT_W-1:0]  pre_shift;

   always_comb begin
      rem_sh    = {acc[XLEN-1:0], opb[XLEN-1]};
      trial     = {1'b0, rem_sh} - {2'b00, opa[XLEN-1:0]};
      pre_shift = CNT_W'(XLEN) - n_iter;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc      <= '0;
         opa      <= '0;
         opb      <= '0;
         count    <= '0;
         div_mode <= 1'b0;
      end else if (load) begin
         count    <= n_iter;
         div_mode <= is_div;
         acc      <= '0;
         if (is_div) begin
            opa <= {{XLEN{1'b0}}, b};
            // Left-align the dividend so a shorter iteration count still
            // consumes its significant bits MSB first.
            opb <= a << pre_shift;
         end else begin
            opa <= {{XLEN{1'b0}}, a};
            opb <= b;
         end
      end else if (step && (count != '0)) begin
         count <= count - CNT_W'(1);
         if (div_mode) begin
            // Partial remainder always fits XLEN bits; the extra top bit is 0.
            if (!trial[XLEN+1]) begin
               acc <= {{(XLEN-1){1'b0}}, trial[XLEN:0]};
               opb <= {opb[XLEN-2:0], 1'b1};
            end else begin
               acc <= {{(XLEN-1){1'b0}}, rem_sh};
               opb <= {opb[XLEN-2:0], 1'b0};
            end
         end else begin
            if (opb[0]) begin
               acc <= acc + opa;
            end
            opa <= opa << 1;
            opb <= opb >> 1;
         end
      end
   end

   assign last = (count == CNT_W'(1));
   assign prod = acc;
   assign quo  = opb;
   assign rem  = acc[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV64M multiply/divide unit in the EX stage.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_i         M-op present in EX this cycle
//   op_i            op code (muldiv_pkg encoding)
//   rs1_i, rs2_i    operands
//   flush_i         EX flush; aborts any op in flight, blocks accept
//   busy_o          stall request, high from the accept cycle until DONE
//   result_valid_o  one-cycle result strobe (DONE state)
//   result_o        result, held until the next DONE
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 64,
   parameter int unsigned OP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic [XLEN-1:0]   rs1_i,
   input  logic [XLEN-1:0]   rs2_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              result_valid_o,
   output logic [XLEN-1:0]   result_o
);

   localparam int unsigned CNT_W = $clog2(XLEN + 1);

   function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   muldiv_state_e state, state_nxt;
   op_dec_t       dec_in;
   logic          accept;

   logic [XLEN-1:0] opa_ext, opb_ext, abs_a, abs_b, dividend;
   logic            sign_a, sign_b, a_is_min, div_zero, div_ovf, special_in, neg_in;
   logic [XLEN-1:0] special_res_in;

   logic            div_q, rem_q, word_q, hi_q, neg_q, special_q;
   logic [XLEN-1:0] special_res_q, res_q, res_calc;

   logic              core_last;
   logic [2*XLEN-1:0] core_prod, prod_signed;
   logic [XLEN-1:0]   core_quo, core_rem, div_pick, div_signed, full_res;

   // Operand preparation and special-case detection for the accept cycle.
   always_comb begin
      dec_in = decode_op(op_i);
      if (dec_in.word) begin
         opa_ext  = dec_in.s1 ? sext_w(rs1_i[31:0]) : {{(XLEN-32){1'b0}}, rs1_i[31:0]};
         opb_ext  = dec_in.s2 ? sext_w(rs2_i[31:0]) : {{(XLEN-32){1'b0}}, rs2_i[31:0]};
         a_is_min = (rs1_i[31:0] == 32'h8000_0000);
         dividend = sext_w(rs1_i[31:0]);
      end else begin
         opa_ext  = rs1_i;
         opb_ext  = rs2_i;
         a_is_min = (rs1_i == {1'b1, {(XLEN-1){1'b0}}});
         dividend = rs1_i;
      end
      sign_a     = dec_in.s1 & opa_ext[XLEN-1];
      sign_b     = dec_in.s2 & opb_ext[XLEN-1];
      abs_a      = sign_a ? -opa_ext : opa_ext;
      abs_b      = sign_b ? -opb_ext : opb_ext;
      div_zero   = dec_in.div && (opb_ext == '0);
      div_ovf    = dec_in.div && dec_in.s1 && a_is_min && (opb_ext == '1);
      special_in = div_zero || div_ovf;
      neg_in     = (dec_in.div && dec_in.rem) ? sign_a : (sign_a ^ sign_b);
      if (div_zero) begin
         special_res_in = dec_in.rem ? dividend : '1;
      end else begin
         special_res_in = dec_in.rem ? '0 : dividend;
      end
   end

   always_comb begin
      state_nxt      = state;
      busy_o         = 1'b0;
      result_valid_o = 1'b0;
      accept         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (valid_i && !flush_i) begin
               accept    = 1'b1;
               busy_o    = 1'b1;
               state_nxt = special_in ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            busy_o = 1'b1;
            if (core_last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            result_valid_o = 1'b1;
            state_nxt      = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (flush_i) begin
         state_nxt      = ST_IDLE;
         result_valid_o = 1'b0;
      end
      if (rst) begin
         busy_o         = 1'b0;
         result_valid_o = 1'b0;
         accept         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         div_q         <= 1'b0;
         rem_q         <= 1'b0;
         word_q        <= 1'b0;
         hi_q          <= 1'b0;
         neg_q         <= 1'b0;
         special_q     <= 1'b0;
         special_res_q <= '0;
         res_q         <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            div_q         <= dec_in.div;
            rem_q         <= dec_in.rem;
            word_q        <= dec_in.word;
            hi_q          <= dec_in.hi;
            neg_q         <= neg_in;
            special_q     <= special_in;
            special_res_q <= special_res_in;
         end
         if (result_valid_o) begin
            res_q <= res_calc;
         end
      end
   end

   muldiv_iter_core #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush_i),
      .load   (accept),
      .is_div (dec_in.div),
      .n_iter (dec_in.word ? CNT_W'(ITER_W) : CNT_W'(ITER_D)),
      .a      (abs_a),
      .b      (abs_b),
      .step   ((state == ST_CALC) && !flush_i),
      .last   (core_last),
      .prod   (core_prod),
      .quo    (core_quo),
      .rem    (core_rem)
   );

   // Sign restoration and result selection from the finished core state.
   always_comb begin
      prod_signed = neg_q ? -core_prod : core_prod;
      div_pick    = rem_q ? core_rem : core_quo;
      div_signed  = neg_q ? -div_pick : div_pick;
      if (div_q) begin
         full_res = div_signed;
      end else if (hi_q) begin
         full_res = prod_signed[2*XLEN-1:XLEN];
      end else begin
         full_res = prod_signed[XLEN-1:0];
      end
      res_calc = word_q ? sext_w(full_res[31:0]) : full_res;
      if (special_q) begin
         res_calc = special_res_q;
      end
   end

   // The result is visible combinationally during DONE and held afterwards.
   assign result_o = result_valid_o ? res_calc : res_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

   localparam int MUL = 0, MULH = 1, MULHSU = 2, MULHU = 3, DIV = 4, DIVU = 5,
                  REM = 6, REMU = 7, MULW = 8, DIVW = 9, DIVUW = 10, REMW = 11, REMUW = 12;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic [3:0]  op_i;
   logic [63:0] rs1_i;
   logic [63:0] rs2_i;
   logic        flush_i;
   logic        busy_o;
   logic        result_valid_o;
   logic [63:0] result_o;

   int checks = 0;
   int passes = 0;

   ex_muldiv_unit #(
      .XLEN (64),
      .OP_W (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .op_i           (op_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .flush_i        (flush_i),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] ref_result(input int op, input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] ps;
      logic [127:0]        pu;
      longint              sa, sb;
      int                  sa32, sb32;
      int unsigned         ua32, ub32;
      logic [31:0]         lo;
      logic [63:0]         r;
      sa = a; sb = b;
      sa32 = a[31:0]; sb32 = b[31:0];
      ua32 = a[31:0]; ub32 = b[31:0];
      r = '0;
      case (op)
         MUL:    r = a * b;
         MULH:   begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
         MULHSU: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = ps[127:64]; end
         MULHU:  begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
         DIV:    if (b == 0) r = '1;
                 else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                 else r = sa / sb;
         DIVU:   r = (b == 0) ? '1 : a / b;
         REM:    if (b == 0) r = a;
                 else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                 else r = sa % sb;
         REMU:   r = (b == 0) ? a : a % b;
         MULW:   begin lo = a[31:0] * b[31:0]; r = sx32(lo); end
         DIVW:   if (sb32 == 0) r = '1;
                 else if (sa32 == 32'h8000_0000 && sb32 == -1) r = sx32(a[31:0]);
                 else r = sx32(sa32 / sb32);
         DIVUW:  r = (ub32 == 0) ? '1 : sx32(ua32 / ub32);
         REMW:   if (sb32 == 0) r = sx32(a[31:0]);
                 else if (sa32 == 32'h8000_0000 && sb32 == -1) r = '0;
                 else r = sx32(sa32 % sb32);
         REMUW:  r = (ub32 == 0) ? sx32(a[31:0]) : sx32(ua32 % ub32);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Cycle (relative to accept) at which the result strobe appears.
   function automatic int ref_latency(input int op, input logic [63:0] a, input logic [63:0] b);
      bit is_div, word, sgn, zero, ovf;
      is_div = (op >= DIV && op <= REMU) || (op >= DIVW && op <= REMUW);
      word   = (op >= MULW);
      sgn    = (op == DIV) || (op == REM) || (op == DIVW) || (op == REMW);
      zero   = word ? (b[31:0] == 0) : (b == 0);
      ovf    = sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (is_div && (zero || ovf)) return 1;
      return word ? 33 : 65;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Call at 1 time unit after a rising edge; that cycle is cycle 0.
   task automatic run_op(input int op, input logic [63:0] a, input logic [63:0] b, input bit keep_valid,
                         output logic [63:0] res, output int done_cyc, output int busy_cnt);
      done_cyc = -1;
      busy_cnt = 0;
      res      = '0;
      valid_i  = 1'b1;
      op_i     = 4'(op);
      rs1_i    = a;
      rs2_i    = b;
      #1;
      for (int c = 0; c < 100 && done_cyc < 0; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
            if (!keep_valid) valid_i = 1'b0;
            #1;
         end
         if (busy_o) busy_cnt++;
         if (result_valid_o) begin
            done_cyc = c;
            res      = result_o;
         end
      end
      valid_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; valid_i = 1'b1; op_i = 4'(MUL); rs1_i = 64'd3; rs2_i = 64'd5; flush_i = 1'b0;
      repeat (3) next_cycle();
      checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else passes++;
      checks++; if (result_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", result_valid_o); else passes++;
      checks++; if (result_o !== 64'd0) $display("FAIL reset_result: got %h expected 0", result_o); else passes++;
      valid_i = 1'b0;
      rst = 1'b0;
      next_cycle();
      checks++; if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy_o); else passes++;
   endtask

   typedef struct {
      int          op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   task automatic test_directed();
      vec_t        v [14];
      logic [63:0] res;
      int          dc, bc;
      v[0]  = '{MUL,    64'd3,                   64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65};
      v[1]  = '{DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 65};
      v[2]  = '{REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65};
      v[3]  = '{MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'd1,                   65};
      v[4]  = '{DIVU,   64'h1234,                64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 1};
      v[5]  = '{REMU,   64'h1234,                64'd0,                   64'h1234,                1};
      v[6]  = '{DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
      v[7]  = '{REMW,   64'h8000_0000,           64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1};
      v[8]  = '{MULW,   64'h7FFF_FFFF,           64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 33};
      v[9]  = '{DIVUW,  64'hFFFF_FFFF,           64'd1,                   64'hFFFF_FFFF_FFFF_FFFF, 33};
      v[10] = '{MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65};
      v[11] = '{MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   65};
      v[12] = '{REMW,   64'h1_8000_0005,         64'h7_0000_0000,         64'hFFFF_FFFF_8000_0005, 1};
      v[13] = '{DIVW,   64'h8000_0000,           64'hFFFF_FFFF,           64'hFFFF_FFFF_8000_0000, 1};
      foreach (v[i]) begin
         next_cycle();
         run_op(v[i].op, v[i].a, v[i].b, 1'b0, res, dc, bc);
         checks++;
         if (res !== v[i].exp) $display("FAIL dir%0d_result: got %h expected %h", i, res, v[i].exp);
         else passes++;
         checks++;
         if (dc != v[i].lat) $display("FAIL dir%0d_latency: got %0d expected %0d", i, dc, v[i].lat);
         else passes++;
         checks++;
         if (bc != v[i].lat) $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, v[i].lat);
         else passes++;
      end
   endtask

   task automatic test_random();
      logic [63:0] a, b, res, exp;
      int          op, kind, dc, bc, lat;
      for (int i = 0; i < 60; i++) begin
         op   = $urandom_range(0, 12);
         kind = $urandom_range(0, 7);
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom};
         case (kind)
            0: b = ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom, 32'd0};
            1: begin
               a = (op >= MULW) ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
               b = (op >= MULW) ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
            end
            2: begin
               a = 64'($urandom_range(0, 100));
               b = 64'($urandom_range(0, 10));
               if ($urandom_range(0, 1) == 1) a = 64'd0 - a;
               if ($urandom_range(0, 1) == 1) b = 64'd0 - b;
            end
            3: b = 64'($urandom_range(1, 3));
            default: ;
         endcase
         exp = ref_result(op, a, b);
         lat = ref_latency(op, a, b);
         next_cycle();
         run_op(op, a, b, 1'b0, res, dc, bc);
         checks++;
         if (res !== exp) $display("FAIL rnd%0d_op%0d_result: a=%h b=%h got %h expected %h", i, op, a, b, res, exp);
         else passes++;
         checks++;
         if (dc != lat) $display("FAIL rnd%0d_op%0d_latency: got %0d expected %0d", i, op, dc, lat);
         else passes++;
         checks++;
         if (bc != lat) $display("FAIL rnd%0d_op%0d_busy_cycles: got %0d expected %0d", i, op, bc, lat);
         else passes++;
      end
   endtask

   task automatic test_flush();
      logic [63:0] prev, res, a, b;
      int          dc, bc;
      bit          strobe;
      next_cycle();
      prev    = result_o;
      valid_i = 1'b1; op_i = 4'(DIV); rs1_i = 64'd0 - 64'd100; rs2_i = 64'd7;
      strobe  = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         next_cycle();
         valid_i = 1'b0;
         flush_i = (c == 10);
         #1;
         if (result_valid_o) strobe = 1'b1;
      end
      checks++; if (busy_o !== 1'b0) $display("FAIL flush_busy_after: got %b expected 0", busy_o); else passes++;
      checks++; if (strobe !== 1'b0) $display("FAIL flush_no_strobe: got %b expected 0", strobe); else passes++;
      checks++; if (result_o !== prev) $display("FAIL flush_result_held: got %h expected %h", result_o, prev); else passes++;
      next_cycle();
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      run_op(MUL, a, b, 1'b0, res, dc, bc);
      checks++; if (res !== ref_result(MUL, a, b)) $display("FAIL flush_next_result: got %h expected %h", res, ref_result(MUL, a, b)); else passes++;
      checks++; if (dc != 65) $display("FAIL flush_next_latency: got %0d expected 65", dc); else passes++;

      // flush while idle must block the accept
      next_cycle();
      valid_i = 1'b1; flush_i = 1'b1; op_i = 4'(MUL); rs1_i = 64'd9; rs2_i = 64'd9;
      #1;
      checks++; if (busy_o !== 1'b0) $display("FAIL flush_idle_busy: got %b expected 0", busy_o); else passes++;
      next_cycle();
      valid_i = 1'b0; flush_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || result_valid_o !== 1'b0)
         $display("FAIL flush_idle_no_accept: busy=%b valid=%b expected 0 0", busy_o, result_valid_o);
      else passes++;
   endtask

   task automatic test_reset_abort();
      logic [63:0] res, a, b;
      int          dc, bc;
      bit          strobe;
      next_cycle();
      valid_i = 1'b1; op_i = 4'(DIV); rs1_i = 64'd12345; rs2_i = 64'd0 - 64'd3;
      strobe  = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         next_cycle();
         valid_i = 1'b0;
         rst     = (c == 5);
         #1;
         if (result_valid_o) strobe = 1'b1;
      end
      checks++; if (busy_o !== 1'b0) $display("FAIL rst_abort_busy: got %b expected 0", busy_o); else passes++;
      checks++; if (strobe !== 1'b0) $display("FAIL rst_abort_no_strobe: got %b expected 0", strobe); else passes++;
      checks++; if (result_o !== 64'd0) $display("FAIL rst_abort_result: got %h expected 0", result_o); else passes++;
      next_cycle();
      a = 64'($urandom_range(1000, 100000));
      b = 64'($urandom_range(1, 100));
      run_op(REMU, a, b, 1'b0, res, dc, bc);
      checks++; if (res !== a % b) $display("FAIL rst_abort_next_result: got %h expected %h", res, a % b); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] a, b, res, prev;
      int          dc, bc;
      bit          strobe;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      next_cycle();
      // valid_i stays high into DONE: the unit must not restart there
      run_op(MULH, a, b, 1'b1, res, dc, bc);
      checks++; if (res !== ref_result(MULH, a, b)) $display("FAIL b2b_first_result: got %h expected %h", res, ref_result(MULH, a, b)); else passes++;
      checks++; if (bc != 65) $display("FAIL b2b_busy_in_done: got %0d expected 65", bc); else passes++;
      next_cycle();
      b = 64'($urandom_range(1, 1000));
      run_op(DIVU, a, b, 1'b0, res, dc, bc);
      checks++; if (res !== a / b) $display("FAIL b2b_second_result: got %h expected %h", res, a / b); else passes++;
      checks++; if (dc != 65) $display("FAIL b2b_second_latency: got %0d expected 65", dc); else passes++;
      prev   = a / b;
      strobe = 1'b0;
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         if (result_valid_o) strobe = 1'b1;
      end
      checks++; if (result_o !== prev) $display("FAIL hold_result: got %h expected %h", result_o, prev); else passes++;
      checks++; if (strobe !== 1'b0) $display("FAIL hold_no_strobe: got %b expected 0", strobe); else passes++;
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; flush_i = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
